// File: rtl/ysyx_25040109_axi_pkg.sv
// Shared response codes, FSM state encodings and address decode for the imem SRAM responder.
package ysyx_25040109_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Wide enough for LATENCY (max 15) plus the optional 0..3 jitter.
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } w_state_t;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/ysyx_25040109_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) supplying response-delay jitter.
module ysyx_25040109_lfsr (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] q_lo
);

  logic [7:0] q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 8'hA5;
    else      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

  assign q_lo = q[1:0];

endmodule

// File: rtl/ysyx_25040109_imem_sram.sv
// AXI-lite style SRAM responder for the fetch unit with fixed-latency read and write FSMs.
// Define YSYX_25040109_SRAM_LFSR_DELAY_EN to add 0..3 cycles of pseudo-random delay per transaction.
module ysyx_25040109_imem_sram
  import ysyx_25040109_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_araddr,
  input  logic        imem_arvalid,
  output logic        imem_arready,
  output logic [31:0] imem_rdata,
  output logic [1:0]  imem_rresp,
  output logic        imem_rvalid,
  input  logic        imem_rready,
  input  logic [31:0] imem_awaddr,
  input  logic        imem_awvalid,
  output logic        imem_awready,
  input  logic [31:0] imem_wdata,
  input  logic [3:0]  imem_wstr,
  input  logic        imem_wvalid,
  output logic        imem_wready,
  output logic [1:0]  imem_bresp,
  output logic        imem_bvalid,
  input  logic        imem_bready
);

  localparam int unsigned      IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0]      SPAN  = 32'(DEPTH_WORDS * 4);
  localparam logic [CNT_W-1:0] LAT   = CNT_W'(LATENCY);

  logic [31:0] mem [DEPTH_WORDS];

  logic [CNT_W-1:0] delay;
`ifdef YSYX_25040109_SRAM_LFSR_DELAY_EN
  logic [1:0] jitter;
  ysyx_25040109_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .q_lo (jitter)
  );
  assign delay = LAT + CNT_W'(jitter);
`else
  assign delay = LAT;
`endif

  // ---------------- read channel ----------------
  r_state_t         r_state, r_state_nx;
  logic [31:0]      r_addr, r_src_addr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_enter_resp, r_hit, ar_hs;
  logic [IDX_W-1:0] r_idx;

  // Ready is gated by rst so it reads 0 during reset and 1 as soon as reset lifts.
  assign imem_arready = rst & (r_state == R_IDLE);
  assign imem_rvalid  = (r_state == R_RESP);
  assign ar_hs        = imem_arvalid & imem_arready;

  // A zero-delay read samples memory at the handshake edge, before r_addr is loaded.
  assign r_src_addr = (r_state == R_IDLE) ? imem_araddr : r_addr;
  assign r_hit      = addr_hit(r_src_addr, ADDR_BASE, SPAN);
  assign r_idx      = IDX_W'((r_src_addr - ADDR_BASE) >> 2);

  always_comb begin
    r_state_nx   = r_state;
    r_enter_resp = 1'b0;
    case (r_state)
      R_IDLE: if (ar_hs) begin
        if (delay == '0) begin
          r_state_nx   = R_RESP;
          r_enter_resp = 1'b1;
        end else begin
          r_state_nx = R_WAIT;
        end
      end
      R_WAIT: if (r_cnt <= CNT_W'(1)) begin
        r_state_nx   = R_RESP;
        r_enter_resp = 1'b1;
      end
      R_RESP: if (imem_rready) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= R_IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      imem_rdata <= '0;
      imem_rresp <= '0;
    end else begin
      r_state <= r_state_nx;
      if (ar_hs) begin
        r_addr <= imem_araddr;
        r_cnt  <= delay;
      end else if (r_state == R_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (r_enter_resp) begin
        imem_rdata <= r_hit ? mem[r_idx] : '0;
        imem_rresp <= r_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // ---------------- write channel ----------------
  w_state_t         w_state, w_state_nx;
  logic [31:0]      w_addr, w_data;
  logic [3:0]       w_strb;
  logic [CNT_W-1:0] w_cnt;
  logic             aw_held, w_held, aw_hs, w_hs, both_held, w_commit, w_hit;
  logic [IDX_W-1:0] w_idx;

  assign imem_awready = rst & (w_state == W_IDLE) & ~aw_held;
  assign imem_wready  = rst & (w_state == W_IDLE) & ~w_held;
  assign imem_bvalid  = (w_state == W_RESP);
  assign aw_hs        = imem_awvalid & imem_awready;
  assign w_hs         = imem_wvalid & imem_wready;
  assign both_held    = (aw_held | aw_hs) & (w_held | w_hs);
  assign w_hit        = addr_hit(w_addr, ADDR_BASE, SPAN);
  assign w_idx        = IDX_W'((w_addr - ADDR_BASE) >> 2);

  always_comb begin
    w_state_nx = w_state;
    w_commit   = 1'b0;
    case (w_state)
      W_IDLE: if (both_held) w_state_nx = W_WAIT;
      W_WAIT: if (w_cnt == '0) begin
        w_state_nx = W_RESP;
        w_commit   = 1'b1;
      end
      W_RESP: if (imem_bready) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state    <= W_IDLE;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      w_strb     <= '0;
      w_cnt      <= '0;
      imem_bresp <= '0;
    end else begin
      w_state <= w_state_nx;
      if (aw_hs) begin
        w_addr  <= imem_awaddr;
        aw_held <= 1'b1;
      end
      if (w_hs) begin
        w_data <= imem_wdata;
        w_strb <= imem_wstr;
        w_held <= 1'b1;
      end
      if (w_state == W_IDLE && both_held) begin
        w_cnt   <= delay;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else if (w_state == W_WAIT && w_cnt != '0) begin
        w_cnt <= w_cnt - CNT_W'(1);
      end
      if (w_commit) imem_bresp <= w_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_commit && w_hit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_strb[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

endmodule
